main_mem_burst: RTL

//  Parametrised successor of the single-cycle main memory. Backing store for the

---
 rtl/main_mem_burst.sv | 132 +++++++++++++
 1 files changed

// File: rtl/main_mem_burst.sv
// Line-burst backing store: a read returns a line LATENCY+LINE_WORDS+1 cycles after accept, a strobed word write completes after LATENCY+2 cycles.
// One operation in flight. o_mem_busy is the only backpressure, and requests are sampled only while idle.
module main_mem_burst #(
    parameter int MEM_DEPTH  = 12,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]            i_mem_read_address,
    output logic                             o_mem_read_done,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] o_cache_line,
    input  logic                             i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]            i_mem_write_address,
    input  logic [DATA_WIDTH-1:0]            i_mem_write_data,
    input  logic [DATA_WIDTH/8-1:0]          i_write_strobe,
    output logic                             o_mem_write_done,
    output logic                             o_mem_busy
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int BYTE_OFF = $clog2(BYTES);
    localparam int LINE_OFF = $clog2(LINE_WORDS);
    localparam int CLW      = LINE_WORDS * DATA_WIDTH;
    localparam int BW       = (LINE_OFF > 0) ? LINE_OFF : 1;
    localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef logic [MEM_DEPTH-1:0] idx_t;
    localparam idx_t LINE_MASK = ~idx_t'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_WRITE, S_DONE} state_t;

    state_t                  state;
    logic                    op_rd;
    idx_t                    base;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [BYTES-1:0]        wr_strb;
    logic [CW-1:0]           wait_cnt;
    logic [BW-1:0]           beat;
    logic [CLW-1:0]          shadow;
    logic [CLW-1:0]          shadow_next;
    logic [DATA_WIDTH-1:0]   mem [0:(1<<MEM_DEPTH)-1];

    idx_t                    rd_req_idx;
    idx_t                    wr_req_idx;
    idx_t                    rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    last_beat;
    logic                    unused_addr_bits;

    // Address bits above the storage size are ignored, so addresses wrap.
    assign rd_req_idx       = i_mem_read_address[BYTE_OFF +: MEM_DEPTH];
    assign wr_req_idx       = i_mem_write_address[BYTE_OFF +: MEM_DEPTH];
    assign unused_addr_bits = ^{i_mem_read_address, i_mem_write_address};
    assign rd_idx           = base + idx_t'(beat);
    assign rd_word          = mem[rd_idx];
    assign last_beat        = (32'(beat) == LINE_WORDS - 1);

    // The final beat goes straight into the output line, so the line is complete on entry to DONE.
    always_comb begin
        shadow_next = shadow;
        shadow_next[int'(beat)*DATA_WIDTH +: DATA_WIDTH] = rd_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            o_mem_busy      <= 1'b0;
            o_mem_read_done <= 1'b0;
            o_mem_write_done<= 1'b0;
            o_cache_line    <= '0;
        end else begin
            o_mem_read_done  <= 1'b0;
            o_mem_write_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat     <= '0;
                    wait_cnt <= '0;
                    if (i_mem_read_req) begin
                        op_rd      <= 1'b1;
                        base       <= rd_req_idx & LINE_MASK;
                        o_mem_busy <= 1'b1;
                        state      <= (LATENCY > 0) ? S_WAIT : S_BURST;
                    end else if (i_mem_write_valid) begin
                        op_rd      <= 1'b0;
                        base       <= wr_req_idx;
                        wr_data    <= i_mem_write_data;
                        wr_strb    <= i_write_strobe;
                        o_mem_busy <= 1'b1;
                        state      <= (LATENCY > 0) ? S_WAIT : S_WRITE;
                    end
                end
                S_WAIT: begin
                    if (32'(wait_cnt) == LATENCY - 1)
                        state <= op_rd ? S_BURST : S_WRITE;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                S_BURST: begin
                    shadow <= shadow_next;
                    if (last_beat) begin
                        o_cache_line    <= shadow_next;
                        o_mem_read_done <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_WRITE: begin
                    o_mem_write_done <= 1'b1;
                    state            <= S_DONE;
                end
                default: begin
                    o_mem_busy <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // A reset arriving in the WRITE cycle cancels the commit.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == S_WRITE) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_strb[b])
                    mem[base][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end
endmodule
